cic_comb_cascade: RTL and testbench

//  Parametrised, time-multiplexed CIC comb (differentiator) cascade for the DSM decimation path.

---
 rtl/cic_comb_cascade.sv | 86 ++++++++
 tb/tb_cic_comb_cascade.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cic_comb_cascade.sv
// cic_comb_cascade: time-multiplexed CIC comb cascade, one stage per clk on a shared subtractor
module cic_comb_cascade #(
  parameter int WIDTH    = 24,
  parameter int STAGES   = 3,
  parameter int CHANNELS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_lr_clk,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out,
  output logic             o_out_valid,
  output logic             o_out_ch,
  output logic             o_busy,
  output logic             o_overrun
);
  localparam int KW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic STEREO = (CHANNELS == 2);
  localparam logic [KW-1:0] K_LAST = KW'(STAGES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state;
  state_t           w_next;
  logic             r_prev_lr;
  logic             r_ch;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_d [CHANNELS][STAGES];
  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic [WIDTH-1:0] w_diff;
  assign w_rise = i_lr_clk & ~r_prev_lr;
  assign w_fall = STEREO & ~i_lr_clk & r_prev_lr;
  assign w_edge = w_rise | w_fall;
  // single shared subtractor; modulo-2^WIDTH wrap is what keeps the CIC exact
  assign w_diff = r_x - r_d[r_ch][r_k];
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next state: accept an edge only when idle, walk all stages, then publish
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE)     w_next = w_edge ? RUN : IDLE;
    else if (r_state == RUN) w_next = (r_k == K_LAST) ? DONE : RUN;
  end
  // datapath, per-channel comb history and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_lr   <= 1'b0;
      r_ch        <= 1'b0;
      r_k         <= '0;
      r_x         <= '0;
      o_out       <= '0;
      o_out_valid <= 1'b0;
      o_out_ch    <= 1'b0;
      o_busy      <= 1'b0;
      o_overrun   <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < STAGES; s++)
          r_d[c][s] <= '0;
    end else begin
      r_prev_lr   <= i_lr_clk;
      o_out_valid <= 1'b0;
      if (w_edge && r_state != IDLE) o_overrun <= 1'b1;
      if (r_state == IDLE && w_edge) begin
        r_x    <= i_in;
        r_ch   <= w_fall;
        r_k    <= '0;
        o_busy <= 1'b1;
      end
      if (r_state == RUN) begin
        r_x            <= w_diff;
        r_d[r_ch][r_k] <= r_x;
        r_k            <= r_k + 1'b1;
      end
      if (r_state == DONE) begin
        o_out       <= r_x;
        o_out_ch    <= r_ch;
        o_out_valid <= 1'b1;
        o_busy      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cic_comb_cascade.sv
// tb_cic_comb_cascade: scoreboard bench over three CIC comb configurations
module tb_cic_comb_cascade;
  typedef struct packed {logic [23:0] d; logic c;} exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lr [3];
  logic [23:0] din [3];
  logic [23:0] dout [3];
  logic        vld [3];
  logic        och [3];
  logic        bsy [3];
  logic        ovr [3];
  logic        pv [3];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        q2 [$];
  int          n_vec = 0;
  int          n_err = 0;
  always #5 clk = ~clk;
  cic_comb_cascade #(.WIDTH(24), .STAGES(3), .CHANNELS(1)) u_s3 (
    .clk(clk), .rst_n(rst_n), .i_lr_clk(lr[0]), .i_in(din[0]), .o_out(dout[0]),
    .o_out_valid(vld[0]), .o_out_ch(och[0]), .o_busy(bsy[0]), .o_overrun(ovr[0]));
  cic_comb_cascade #(.WIDTH(24), .STAGES(1), .CHANNELS(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .i_lr_clk(lr[1]), .i_in(din[1]), .o_out(dout[1]),
    .o_out_valid(vld[1]), .o_out_ch(och[1]), .o_busy(bsy[1]), .o_overrun(ovr[1]));
  cic_comb_cascade #(.WIDTH(24), .STAGES(1), .CHANNELS(2)) u_st (
    .clk(clk), .rst_n(rst_n), .i_lr_clk(lr[2]), .i_in(din[2]), .o_out(dout[2]),
    .o_out_valid(vld[2]), .o_out_ch(och[2]), .o_busy(bsy[2]), .o_overrun(ovr[2]));
  function automatic int stg(input int u);
    return (u == 0) ? 3 : 1;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(input int u, input logic [23:0] e, input logic c);
    exp_t x;
    x = '{d: e, c: c};
    case (u)
      0: q0.push_back(x);
      1: q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endtask
  task automatic pop(input int u);
    exp_t e;
    logic ok;
    ok = 1'b0;
    e = '0;
    case (u)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
    chk("expected_output", {31'd0, ok}, 32'd1);
    if (ok) begin
      chk("out", {8'd0, dout[u]}, {8'd0, e.d});
      chk("out_ch", {31'd0, och[u]}, {31'd0, e.c});
    end
  endtask
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (vld[u]) begin
        chk("valid_gap", {31'd0, pv[u]}, 32'd0);
        pop(u);
      end
      pv[u] = vld[u];
    end
  end
  task automatic send(input int u, input logic lvl, input logic [23:0] v, input logic [23:0] e, input logic c);
    int n;
    @(negedge clk);
    lr[u] = lvl;
    din[u] = v;
    push(u, e, c);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!vld[u] && n < 20);
    chk("latency", n - 1, stg(u) + 1);
  endtask
  task automatic rise(input int u, input logic [23:0] v, input logic [23:0] e);
    send(u, 1'b1, v, e, 1'b0);
    @(negedge clk);
    lr[u] = 1'b0;
  endtask
  task automatic drain(input int u);
    int s;
    repeat (2) @(negedge clk);
    s = (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
    chk("drain", s, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) lr[u] = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic impulse3();
    logic [23:0] ex [6];
    ex = '{24'h000001, 24'hFFFFFD, 24'h000003, 24'hFFFFFF, 24'h000000, 24'h000000};
    for (int i = 0; i < 6; i++) rise(0, (i == 0) ? 24'd1 : 24'd0, ex[i]);
    drain(0);
  endtask
  initial begin
    logic [23:0] st [5];
    int n;
    for (int u = 0; u < 3; u++) begin
      lr[u] = 1'b0;
      din[u] = '0;
      pv[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_out", {8'd0, dout[u]}, 32'd0);
      chk("rst_valid", {31'd0, vld[u]}, 32'd0);
      chk("rst_ch", {31'd0, och[u]}, 32'd0);
      chk("rst_busy", {31'd0, bsy[u]}, 32'd0);
      chk("rst_overrun", {31'd0, ovr[u]}, 32'd0);
    end
    rst_n = 1'b1;
    impulse3();
    do_reset();
    st = '{24'd5, 24'hFFFFF6, 24'd5, 24'd0, 24'd0};
    for (int i = 0; i < 5; i++) rise(0, 24'd5, st[i]);
    drain(0);
    do_reset();
    rise(1, 24'h7FFFFF, 24'h7FFFFF);
    rise(1, 24'h800000, 24'h000001);
    rise(1, 24'h000000, 24'h800000);
    drain(1);
    do_reset();
    send(2, 1'b1, 24'd7, 24'd7, 1'b0);
    send(2, 1'b0, 24'd9, 24'd9, 1'b1);
    send(2, 1'b1, 24'd7, 24'd0, 1'b0);
    send(2, 1'b0, 24'd0, 24'hFFFFF7, 1'b1);
    send(2, 1'b1, 24'd7, 24'd0, 1'b0);
    send(2, 1'b0, 24'd0, 24'd0, 1'b1);
    drain(2);
    chk("stereo_overrun", {31'd0, ovr[2]}, 32'd0);
    do_reset();
    @(negedge clk);
    lr[0] = 1'b1;
    din[0] = 24'd1;
    push(0, 24'd1, 1'b0);
    @(posedge clk);
    #1;
    chk("ovr_busy", {31'd0, bsy[0]}, 32'd1);
    chk("ovr_clear", {31'd0, ovr[0]}, 32'd0);
    @(negedge clk);
    lr[0] = 1'b0;
    @(negedge clk);
    lr[0] = 1'b1;
    din[0] = 24'h000055;
    @(posedge clk);
    #1;
    chk("ovr_set", {31'd0, ovr[0]}, 32'd1);
    n = 0;
    while (!vld[0] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ovr_latency", n, 2);
    repeat (10) @(negedge clk);
    chk("ovr_sticky", {31'd0, ovr[0]}, 32'd1);
    chk("ovr_idle", {31'd0, bsy[0]}, 32'd0);
    drain(0);
    do_reset();
    chk("ovr_reset", {31'd0, ovr[0]}, 32'd0);
    rise(0, 24'd7, 24'd7);
    @(negedge clk);
    lr[0] = 1'b1;
    din[0] = 24'd1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    lr[0] = 1'b0;
    q0.delete();
    #1;
    chk("mid_rst_out", {8'd0, dout[0]}, 32'd0);
    chk("mid_rst_valid", {31'd0, vld[0]}, 32'd0);
    chk("mid_rst_busy", {31'd0, bsy[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    impulse3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
